mux8_rr_arbiter: RTL
====================

// Module: mux8_rr_arbiter
// PURPOSE
//  Round-robin arbiter and scheduler for the shared 8-to-1, width-bit data-flow mux.
//  Eight requesters each present a data word plus a req line.
//  The block picks one requester fairly and drives the mux select.
//  It captures the selected word into an output register and hands it downstream
//  with a valid/ready handshake, so the shared mux and its output path never see
//  two owners at once.
// PARAMETERS
//  width   4   data width of each input word and of out_data
//  swidth  3   select width; fixed at 3 for 8 inputs (2**swidth == 8)
// PORTS
//  clk        in   1        single clock; all state updates on posedge
//  rst        in   1        reset, synchronous, active-high
//  req        in   8        req[k]=1: requester k has word on ik
//  i0..i7     in   width    requester data words; ik pairs with req[k]
//  out_ready  in   1        downstream accepts out_data this cycle
//  out_valid  out  1        out_data/out_sel hold a granted word
//  out_data   out  width    registered snapshot of the granted word
//  out_sel    out  swidth   index of the granted requester (mux select)
//  ack        out  8        one-hot 1-cycle pulse: word k transferred (handshake cycle)
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - Next cycle: out_valid=0, out_data=0, out_sel=0, ack=0, rr pointer ptr=0, state IDLE.
//   - Takes priority over every other event.
//   - Reset during BUSY drops the in-flight word; no ack is issued for it.
//  FSM: IDLE (out_valid=0) and BUSY (out_valid=1).
//  Eligible set:
//   - IDLE: E = req.
//   - BUSY: E = req & ~onehot(out_sel). The word being transferred cannot re-win on its handshake edge.
//  Arbitration: search E starting at index ptr, then ptr+1, ... wrapping 7->0. The first hit k wins.
//  On a grant to k at a posedge: out_sel<=k, out_data<=ik (snapshot), out_valid<=1, ptr<=(k+1) mod 8.
//  IDLE transitions:
//   - E!=0 -> grant, go BUSY.
//   - E==0 -> stay IDLE.
//  BUSY transitions:
//   - out_ready=0 -> hold. out_data and out_sel are stable even if ik or req change.
//   - out_ready=1 -> handshake; ack[out_sel] is 1 combinationally in that cycle (ack = onehot(out_sel) & {8{out_valid & out_ready}}).
//   - Handshake with E!=0 -> new grant on the same edge; stay BUSY with no bubble. Full throughput is 1 word/cycle.
//   - Handshake with E==0 -> IDLE, out_valid<=0. out_data and out_sel retain their last values.
//  Latency: req[k] high at posedge n while IDLE -> out_valid=1 with word k during cycle n+1.
//  Requester protocol:
//   - Keep req[k] and ik stable until ack[k]; drop req[k] after ack[k] unless another word is pending.
//   - Deasserting req[k] after it is granted does not cancel the transfer.
//  Fairness: with all 8 requesting, grants cycle 0,1,..,7,0,...
//   - Worst-case wait is 7 transfers.
//  Widths: ptr and out_sel are swidth bits; wrap is natural mod-8 overflow.
//  Everything is purely synchronous, with no combinational path from out_ready to out_data/out_sel.
// TESTING
//  1 Single request:
//    - Stimulus: after reset, req=8'b0000_0100, i2=4'hC, out_ready=1.
//    - Response: next cycle out_valid=1, out_sel=2, out_data=4'hC, ack=8'b0000_0100; then IDLE.
//  2 Back-to-back:
//    - Stimulus: req=8'hFF, ik=k+4'h8, out_ready=1.
//    - Response: out_sel 0,1,..,7,0 on consecutive cycles, out_data=8..F, no bubbles.
//  3 Backpressure:
//    - Stimulus: grant on 3 with i3=4'hD, out_ready=0 for 5 cycles, i3 changed to 4'h1 mid-hold.
//    - Response: out_data=4'hD, out_sel=3 stable, ack=0; ack[3] only when out_ready=1.
//  4 Pointer fairness:
//    - Stimulus: after a grant to 4 (ptr=5), req=8'b0100_0001.
//    - Response: grants 6 then 0.
//  5 Wrap-around and self-exclusion:
//    - Stimulus: after a grant to 7 (ptr=0), req=8'b1000_0001 held high.
//    - Response: grants 0, 7, 0, ...; never two consecutive grants to one index.
//  6 Reset mid-transfer:
//    - Stimulus: out_valid=1, out_ready=0, rst=1 for 1 cycle.
//    - Response: next cycle all outputs 0, no ack; then req=8'hFF -> first grant to 0.

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for a shared 8-to-1 data mux. It grants one requester at a
// time, snapshots the granted word into an output register and hands it downstream
// over a valid/ready handshake. A new grant can land on the handshake edge, so
// throughput is one word per cycle.
module mux8_rr_arbiter #(
    parameter int width  = 4,
    parameter int swidth = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        req,
    input  logic [width-1:0]  i0,
    input  logic [width-1:0]  i1,
    input  logic [width-1:0]  i2,
    input  logic [width-1:0]  i3,
    input  logic [width-1:0]  i4,
    input  logic [width-1:0]  i5,
    input  logic [width-1:0]  i6,
    input  logic [width-1:0]  i7,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [width-1:0]  out_data,
    output logic [swidth-1:0] out_sel,
    output logic [7:0]        ack
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    logic [swidth-1:0] ptr;

    logic [width-1:0]  words [8];
    logic [7:0]        sel_oh;
    logic              hs;
    logic [7:0]        elig;
    logic [swidth:0]   pick;
    logic              found;
    logic [swidth-1:0] win;
    logic              can_grant;

    // Round-robin search: the first set bit of e at or after p (wrapping 7->0)
    // wins. The loop runs from the farthest offset down so the nearest hit is
    // the one that sticks. MSB of the result flags that a winner exists.
    function automatic logic [swidth:0] rr_pick(input logic [7:0] e,
                                                input logic [swidth-1:0] p);
        logic [swidth-1:0] idx;
        rr_pick = '0;
        for (int i = 7; i >= 0; i--) begin
            idx = p + swidth'(i);
            if (e[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    assign words[0] = i0;
    assign words[1] = i1;
    assign words[2] = i2;
    assign words[3] = i3;
    assign words[4] = i4;
    assign words[5] = i5;
    assign words[6] = i6;
    assign words[7] = i7;

    // Stage p0: eligibility and arbitration on the current inputs and pointer.
    // The word currently being handed over is masked so it cannot re-win on
    // its own handshake edge.
    assign sel_oh    = 8'b1 << out_sel;
    assign hs        = out_valid & out_ready;
    assign elig      = (state == BUSY) ? (req & ~sel_oh) : req;
    assign pick      = rr_pick(elig, ptr);
    assign found     = pick[swidth];
    assign win       = pick[swidth-1:0];
    assign can_grant = (state == IDLE) | out_ready;

    // Handshake pulse for the word being transferred this cycle.
    assign ack = sel_oh & {8{hs}};

    // Stage p1: grant/hold/release FSM with registered output word and select.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (can_grant && found) begin
            state     <= BUSY;
            out_valid <= 1'b1;
            out_data  <= words[win];
            out_sel   <= win;
            ptr       <= win + swidth'(1);
        end else if (state == BUSY && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end

endmodule
